// File: rtl/spi_ss_pkg.sv
// Shared definitions for the SPI slave-select / frame-timing controller:
// state encoding, spi_mode encodings and the frame-length clamp helper.
package spi_ss_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    CONT = 2'd2,
    GAP  = 2'd3
  } ss_state_e;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_WAIT = 2'b01;

  // Zero or oversize frame lengths fall back to the maximum frame length.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_bits);
    return ((len == 0) || (len > max_bits)) ? max_bits : len;
  endfunction

endpackage

// File: rtl/spi_ss_decoder.sv
// Slave-select decoder: one-hot active-low select from a slave index.
// Ports:
//   i_sel    - slave index; indices >= NUM_SS select nobody
//   i_active - when 0 all selects stay high
//   o_ss_n   - active-low selects, at most one bit low
module spi_ss_decoder
  import spi_ss_pkg::*;
#(
  parameter int unsigned NUM_SS = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic [SEL_W-1:0]  i_sel,
  input  logic              i_active,
  output logic [NUM_SS-1:0] o_ss_n
);

  always_comb begin
    o_ss_n = '1;
    for (int unsigned i = 0; i < NUM_SS; i++) begin
      if (i_active && (i_sel == SEL_W'(i))) o_ss_n[i] = 1'b0;
    end
  end

endmodule

// File: rtl/spi_multi_slave_select.sv
// Master-side chip-select and transfer-timing controller for the APB SPI core.
// Times each frame as BaudRateDivisor*2*frame_len PCLK cycles with the chosen
// slave select held low, then issues a delayed receive strobe. Supports
// back-to-back framing with SS held low, an inter-frame gap, abort on loss of
// enable and overrun flagging.
// Ports:
//   PCLK, PRESETn   - clock, asynchronous active-low reset
//   spi_mode, mstr, spiswai - enable qualification
//   send_data       - one-cycle frame start request
//   BaudRateDivisor, frame_len, ss_sel, ss_cont - frame configuration
//   ss_n            - active-low slave selects
//   receive_data    - one-cycle pulse after frame completion
//   tip, busy       - transfer in progress / controller not idle
//   abort, overrun  - one-cycle status pulses
module spi_multi_slave_select
  import spi_ss_pkg::*;
#(
  parameter int unsigned NUM_SS   = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned DIV_W    = 12,
  parameter int unsigned MAX_BITS = 16,
  parameter int unsigned LEN_W    = 5,
  parameter int unsigned GAP_CYC  = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [1:0]        spi_mode,
  input  logic              mstr,
  input  logic              spiswai,
  input  logic              send_data,
  input  logic [DIV_W-1:0]  BaudRateDivisor,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic              ss_cont,
  output logic [NUM_SS-1:0] ss_n,
  output logic              receive_data,
  output logic              tip,
  output logic              busy,
  output logic              abort,
  output logic              overrun
);

  localparam int unsigned TGT_W = DIV_W + LEN_W + 1;
  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  ss_state_e          r_state;
  logic [TGT_W-1:0]   r_count;
  logic [DIV_W-1:0]   r_brd_l;
  logic [LEN_W-1:0]   r_len_l;
  logic [SEL_W-1:0]   r_sel_l;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [NUM_SS-1:0]  r_ss_n;
  logic               r_rcv;
  logic               r_receive_data;
  logic               r_tip;
  logic               r_busy;
  logic               r_abort;
  logic               r_overrun;

  logic               w_en;
  logic [DIV_W-1:0]   w_brd;
  logic [LEN_W-1:0]   w_len;
  logic [TGT_W-1:0]   w_target;
  logic               w_last;
  logic [SEL_W-1:0]   w_dec_sel;
  logic [NUM_SS-1:0]  w_ss_dec;

  assign w_en     = mstr & ((spi_mode == MODE_RUN) | ((spi_mode == MODE_WAIT) & ~spiswai));
  assign w_brd    = (BaudRateDivisor == '0) ? DIV_W'(1) : BaudRateDivisor;
  assign w_len    = LEN_W'(clamp_len(32'(frame_len), MAX_BITS));
  // Full-width product of the latched values; the extra bit absorbs the *2.
  assign w_target = TGT_W'(r_brd_l) * TGT_W'({r_len_l, 1'b0});
  assign w_last   = (r_count == (w_target - TGT_W'(1)));

  // A new frame selects from the live index; continuation frames keep the latched one.
  assign w_dec_sel = (r_state == IDLE) ? ss_sel : r_sel_l;

  spi_ss_decoder #(
    .NUM_SS (NUM_SS),
    .SEL_W  (SEL_W)
  ) u_dec (
    .i_sel    (w_dec_sel),
    .i_active (w_en),
    .o_ss_n   (w_ss_dec)
  );

  // Frame state machine, counters and registered outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_brd_l        <= '0;
      r_len_l        <= '0;
      r_sel_l        <= '0;
      r_gap_cnt      <= '0;
      r_ss_n         <= '1;
      r_rcv          <= 1'b0;
      r_receive_data <= 1'b0;
      r_tip          <= 1'b0;
      r_busy         <= 1'b0;
      r_abort        <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_rcv          <= 1'b0;
      r_abort        <= 1'b0;
      r_overrun      <= (r_state == XFER) && send_data;
      r_receive_data <= r_rcv;
      case (r_state)
        IDLE: begin
          if (w_en && send_data) begin
            r_state <= XFER;
            r_count <= '0;
            r_brd_l <= w_brd;
            r_len_l <= w_len;
            r_sel_l <= ss_sel;
            r_ss_n  <= w_ss_dec;
            r_tip   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        XFER: begin
          if (!w_en) begin
            // Loss of enable beats the terminal count: no strobe for this frame.
            r_state <= IDLE;
            r_ss_n  <= '1;
            r_abort <= 1'b1;
            r_tip   <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_last) begin
            r_rcv <= 1'b1;
            if (ss_cont) begin
              r_state <= CONT;
              r_tip   <= ~&r_ss_n;
            end else begin
              r_ss_n <= '1;
              r_tip  <= 1'b0;
              if (GAP_CYC == 0) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state   <= GAP;
                r_gap_cnt <= '0;
              end
            end
          end else begin
            r_count <= r_count + TGT_W'(1);
          end
        end
        CONT: begin
          if (!w_en) begin
            r_state <= IDLE;
            r_ss_n  <= '1;
            r_abort <= 1'b1;
            r_tip   <= 1'b0;
            r_busy  <= 1'b0;
          end else if (send_data) begin
            // Relatch timing only; the decoder reproduces the held select, so SS does not glitch.
            r_state <= XFER;
            r_count <= '0;
            r_brd_l <= w_brd;
            r_len_l <= w_len;
            r_ss_n  <= w_ss_dec;
            r_tip   <= 1'b1;
          end else if (!ss_cont) begin
            r_ss_n <= '1;
            r_tip  <= 1'b0;
            if (GAP_CYC == 0) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= GAP;
              r_gap_cnt <= '0;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_W'(GAP_CYC - 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ss_n         = r_ss_n;
  assign receive_data = r_receive_data;
  assign tip          = r_tip;
  assign busy         = r_busy;
  assign abort        = r_abort;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_spi_multi_slave_select.sv
// Self-checking bench for spi_multi_slave_select. Expected strobe cycles and
// SS-low run lengths are queued when a frame is launched and retired by the
// monitors when the DUT produces them.
module tb_spi_multi_slave_select;

  logic        PCLK;
  logic        PRESETn;
  logic [1:0]  spi_mode;
  logic        mstr;
  logic        spiswai;
  logic        send_data;
  logic [11:0] BaudRateDivisor;
  logic [4:0]  frame_len;
  logic [2:0]  ss_sel;
  logic        ss_cont;
  logic [3:0]  ss_n;
  logic        receive_data;
  logic        tip;
  logic        busy;
  logic        abort;
  logic        overrun;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int rcv_q[$];
  int abt_q[$];
  int ovr_q[$];
  int run_q[$];

  int         run_len = 0;
  logic [3:0] prev_ss = 4'hF;

  spi_multi_slave_select #(
    .NUM_SS   (4),
    .SEL_W    (3),
    .DIV_W    (12),
    .MAX_BITS (16),
    .LEN_W    (5),
    .GAP_CYC  (2)
  ) dut (
    .PCLK            (PCLK),
    .PRESETn         (PRESETn),
    .spi_mode        (spi_mode),
    .mstr            (mstr),
    .spiswai         (spiswai),
    .send_data       (send_data),
    .BaudRateDivisor (BaudRateDivisor),
    .frame_len       (frame_len),
    .ss_sel          (ss_sel),
    .ss_cont         (ss_cont),
    .ss_n            (ss_n),
    .receive_data    (receive_data),
    .tip             (tip),
    .busy            (busy),
    .abort           (abort),
    .overrun         (overrun)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
    end
  endtask

  function automatic int exp_target(input int brd, input int len);
    int b, l;
    b = (brd == 0) ? 1 : brd;
    l = ((len == 0) || (len > 16)) ? 16 : len;
    return b * 2 * l;
  endfunction

  // Strobe monitor: each pulse retires the oldest expectation of its kind.
  always @(negedge PCLK) begin
    if (receive_data) begin
      if (rcv_q.size() == 0) chk("rcv_unexpected", cyc, 0);
      else                   chk("rcv_cycle", cyc, rcv_q.pop_front());
    end
    if (abort) begin
      if (abt_q.size() == 0) chk("abort_unexpected", cyc, 0);
      else                   chk("abort_cycle", cyc, abt_q.pop_front());
    end
    if (overrun) begin
      if (ovr_q.size() == 0) chk("overrun_unexpected", cyc, 0);
      else                   chk("overrun_cycle", cyc, ovr_q.pop_front());
    end
  end

  // SS monitor: length of each contiguous low run, and at most one select low.
  always @(negedge PCLK) begin
    if (ss_n !== 4'hF) begin
      run_len <= run_len + 1;
    end else if (run_len > 0) begin
      if (run_q.size() == 0) chk("ss_run_unexpected", run_len, 0);
      else                   chk("ss_low_run", run_len, run_q.pop_front());
      run_len <= 0;
    end
    if (ss_n !== prev_ss) chk("ss_onehot", 32'($countones(~ss_n) <= 1), 1);
    prev_ss <= ss_n;
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge PCLK);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge PCLK);
    while (busy && (n < budget)) begin
      @(negedge PCLK);
      n++;
    end
    chk("idle_wait", 32'(busy), 0);
  endtask

  // Launches a frame; s is the edge that samples send_data (ss_n low from there).
  task automatic start_frame(input int brd, input int len, input int sel, input bit cont,
                             input bit exp_rcv, output int s, output int tgt);
    @(negedge PCLK);
    BaudRateDivisor = 12'(brd);
    frame_len       = 5'(len);
    ss_sel          = 3'(sel);
    ss_cont         = cont;
    send_data       = 1'b1;
    s   = cyc + 1;
    tgt = exp_target(brd, len);
    if (exp_rcv) rcv_q.push_back(s + tgt + 1);
    @(negedge PCLK);
    send_data = 1'b0;
  endtask

  initial begin
    int s, s2, t, c;
    PRESETn = 1'b0; spi_mode = 2'b00; mstr = 1'b0; spiswai = 1'b0; send_data = 1'b0;
    BaudRateDivisor = '0; frame_len = '0; ss_sel = '0; ss_cont = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("rst_ss_n", 32'(ss_n), 32'hF);
    chk("rst_receive_data", 32'(receive_data), 0);
    chk("rst_abort", 32'(abort), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tip", 32'(tip), 0);
    PRESETn = 1'b1;
    mstr = 1'b1;

    // Basic frame on slave 1, then send_data during GAP is ignored.
    start_frame(2, 8, 1, 1'b0, 1'b1, s, t);
    run_q.push_back(32);
    chk("t1_ss_first", 32'(ss_n), 32'hD);
    chk("t1_tip", 32'(tip), 1);
    chk("t1_busy", 32'(busy), 1);
    wait_until(s + 31);
    chk("t1_ss_last", 32'(ss_n), 32'hD);
    wait_until(s + 32);
    chk("t1_ss_released", 32'(ss_n), 32'hF);
    chk("t1_tip_gap", 32'(tip), 0);
    send_data = 1'b1;
    @(negedge PCLK);
    send_data = 1'b0;
    chk("t1_busy_gap", 32'(busy), 1);
    wait_until(s + 34);
    chk("t1_busy_done", 32'(busy), 0);

    // Zero divisor and zero length; mid-frame input changes are ignored.
    start_frame(0, 0, 0, 1'b0, 1'b1, s, t);
    run_q.push_back(32);
    BaudRateDivisor = 12'd7;
    frame_len       = 5'd3;
    wait_idle(200);

    // Long frame whose cycle count needs more than 16 bits.
    start_frame(2048, 16, 3, 1'b0, 1'b1, s, t);
    run_q.push_back(65536);
    wait_idle(70000);

    // Continuous framing: two frames with SS held low on slave 0.
    start_frame(1, 4, 0, 1'b1, 1'b1, s, t);
    wait_until(s + 10);
    chk("t4_ss_cont", 32'(ss_n), 32'hE);
    chk("t4_busy_cont", 32'(busy), 1);
    wait_until(s + 11);
    start_frame(1, 4, 0, 1'b1, 1'b1, s2, t);
    wait_until(s2 + 11);
    chk("t4_ss_hold", 32'(ss_n), 32'hE);
    ss_cont = 1'b0;
    c = cyc;
    run_q.push_back(c + 1 - s);
    wait_until(c + 1);
    chk("t4_ss_rise", 32'(ss_n), 32'hF);
    wait_idle(50);

    // Wait mode, stop-in-wait raised mid-frame: abort, no receive strobe.
    spi_mode = 2'b01;
    start_frame(2, 8, 2, 1'b0, 1'b0, s, t);
    abt_q.push_back(s + 10);
    run_q.push_back(10);
    wait_until(s + 9);
    chk("t5_ss_low", 32'(ss_n), 32'hB);
    spiswai = 1'b1;
    wait_until(s + 10);
    chk("t5_ss_abort", 32'(ss_n), 32'hF);
    chk("t5_busy_abort", 32'(busy), 0);
    spiswai  = 1'b0;
    spi_mode = 2'b00;
    repeat (3) @(negedge PCLK);

    // send_data in mid-frame flags overrun and leaves the frame length alone.
    start_frame(1, 8, 3, 1'b0, 1'b1, s, t);
    run_q.push_back(16);
    ovr_q.push_back(s + 4);
    wait_until(s + 3);
    send_data = 1'b1;
    @(negedge PCLK);
    send_data = 1'b0;
    wait_idle(100);

    // Out-of-range index: no select, frame still timed.
    start_frame(1, 2, 5, 1'b0, 1'b1, s, t);
    wait_until(s + 1);
    chk("t7_ss_none", 32'(ss_n), 32'hF);
    chk("t7_tip", 32'(tip), 1);
    wait_idle(50);

    // Request while disabled is ignored.
    mstr = 1'b0;
    @(negedge PCLK);
    send_data = 1'b1;
    @(negedge PCLK);
    send_data = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("t8_busy_disabled", 32'(busy), 0);
    chk("t8_ss_disabled", 32'(ss_n), 32'hF);
    mstr = 1'b1;

    // Asynchronous reset mid-frame: everything back to reset values, no strobe.
    start_frame(2, 8, 0, 1'b0, 1'b0, s, t);
    run_q.push_back(4);
    wait_until(s + 3);
    #2 PRESETn = 1'b0;
    #1;
    chk("t9_ss_reset", 32'(ss_n), 32'hF);
    chk("t9_busy_reset", 32'(busy), 0);
    chk("t9_tip_reset", 32'(tip), 0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (6) @(negedge PCLK);
    chk("t9_no_rcv", 32'(receive_data), 0);

    chk("rcv_q_drained", 32'(rcv_q.size()), 0);
    chk("abort_q_drained", 32'(abt_q.size()), 0);
    chk("overrun_q_drained", 32'(ovr_q.size()), 0);
    chk("run_q_drained", 32'(run_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_multi_slave_select.md
Name: spi_multi_slave_select

Overview:
- Master-side chip-select and transfer-timing controller for the APB SPI core.
- Drives NUM_SS active-low slave selects and times each frame from the baud divisor and a programmable frame length.
- Generates the delayed receive strobe that tells the shift register MISO data is complete.
- Adds continuous (back-to-back) framing with SS held low, a programmable inter-frame gap, abort on mode loss, and overrun flagging.

Parameters:
- NUM_SS, 4, number of slave-select outputs (1..16).
- SEL_W, 2, width of ss_sel; must satisfy 2^SEL_W >= NUM_SS.
- DIV_W, 12, width of BaudRateDivisor.
- MAX_BITS, 16, maximum frame length in bits.
- LEN_W, 5, width of frame_len; must satisfy 2^LEN_W > MAX_BITS.
- GAP_CYC, 2, PCLK cycles SS stays high between non-continuous frames (0 allowed).

Ports:
- PCLK  in  1  APB clock; all logic on posedge.
- PRESETn  in  1  reset, asynchronous, active-low.
- spi_mode  in  2  00 = run, 01 = wait, others = stop.
- mstr  in  1  master enable.
- spiswai  in  1  stop-in-wait; while in wait mode, blocks operation when 1.
- send_data  in  1  one-cycle request to start a frame.
- BaudRateDivisor  in  DIV_W  SCK half-period in PCLK cycles; 0 is treated as 1.
- frame_len  in  LEN_W  bits per frame; 0 or >MAX_BITS is clamped to MAX_BITS.
- ss_sel  in  SEL_W  target slave index; an index >= NUM_SS selects no slave, but the frame is still timed.
- ss_cont  in  1  hold SS low after a frame and wait for the next send_data.
- ss_n  out  NUM_SS  active-low slave selects; at most one bit low at any time.
- receive_data  out  1  one-cycle pulse after frame completion.
- tip  out  1  transfer in progress; equals (~&ss_n) OR (state == XFER).
- busy  out  1  state != IDLE.
- abort  out  1  one-cycle pulse when a frame or hold is killed by loss of enable.
- overrun  out  1  one-cycle pulse when send_data arrives in XFER.

Behaviour:
- Enable: en = mstr & (spi_mode==00 | (spi_mode==01 & ~spiswai)).
- Reset values: ss_n all 1, receive_data 0, abort 0, overrun 0, state IDLE, count 0, rcv 0.
- Reset mid-frame returns to these values asynchronously; no receive_data is issued for that frame.
- Frame latch: on frame start, register BRD_l = max(BRD, 1), LEN_l = clamped frame_len, and SEL_l = ss_sel.
- Target is computed from the latched values: target = BRD_l * 2 * LEN_l.
  - Compute at full width, DIV_W + LEN_W + 1 bits; no truncation.
  - Input changes mid-frame have no effect.
- State IDLE:
  - en & send_data -> XFER next cycle: ss_n[SEL_l] = 0, count = 0.
  - send_data with en = 0 is ignored.
- State XFER:
  - count increments every cycle.
  - At count == target-1: rcv = 1 for one cycle, then go to CONT if ss_cont = 1, else GAP (or IDLE if GAP_CYC = 0).
  - SS is low for exactly target cycles.
  - send_data in XFER: ignored; overrun pulses the next cycle.
- State CONT:
  - SS stays low.
  - send_data -> relatch BRD_l and LEN_l (SEL_l is kept), count = 0, back to XFER. No SS glitch.
  - ss_cont = 0 -> ss_n all 1, go to GAP.
- State GAP:
  - ss_n all 1 for GAP_CYC cycles, then IDLE.
  - send_data during GAP is ignored; it does not set overrun.
- Abort: en falling in XFER or CONT -> next cycle ss_n all 1, abort pulses, state IDLE, rcv suppressed.
- receive_data = rcv registered one cycle later, so it rises 2 cycles after the last XFER cycle.
  - The abort rule does not cancel an rcv already issued.
- Simultaneous events:
  - If en drops on the same cycle as count == target-1, abort wins and no rcv is generated.
  - If send_data arrives on the same cycle CONT is entered, it is honoured on the following cycle only if still asserted; send_data is a pulse, so the bench must present it in CONT.

Decomposition:
- Package spi_ss_pkg: state encoding (IDLE, XFER, CONT, GAP), spi_mode encodings (RUN=2'b00, WAIT=2'b01), and the MAX_BITS clamp function.
- One sub-module, spi_ss_decoder: combinational SEL_l / active -> one-hot active-low ss_n, with out-of-range indices giving all ones.
- The state machine and counter stay in the top module.

Test Plan:
- BRD=2, frame_len=8, ss_sel=1, run mode, send_data pulse -> ss_n=4'b1101 for 32 cycles; receive_data high 2 cycles after the last low cycle; then ss_n=4'b1111, with GAP=2 before busy drops.
- BRD=0, frame_len=0 -> treated as 1 and 16; SS low 32 cycles.
- BRD=4095, frame_len=16 -> SS low for 131040 cycles, with no counter truncation.
- ss_cont=1, two send_data pulses 5 cycles apart in CONT, BRD=1, len=4 -> ss_n[0] stays low continuously; two receive_data pulses; SS rises one cycle after ss_cont drops.
- Wait mode with spiswai raised at cycle 10 of a 32-cycle frame -> ss_n all 1 at cycle 11; abort pulses once; no receive_data.
- send_data in mid-XFER -> overrun pulse once; frame length unchanged. ss_sel=5 with NUM_SS=4 -> ss_n stays 1111, tip=1 for the frame, and receive_data still pulses.
